mem_port_arbiter: RTL

//  Shares one single-ported, fixed-latency memory between the pipeline's fetch (IF) and

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and data stages; one access in flight.
// Grant is combinational in IDLE; the response appears MEM_LAT cycles later.
// Data has priority, and a starvation bound forces a fetch grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              busy
);
    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam bit SINGLE = (MEM_LAT == 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   starve_cnt;
    logic               owner_if;
    logic               owner_d;
    logic               owner_st;
    logic               cancel;

    logic idle;
    logic starved;
    logic done_wait;
    logic done_now;
    logic done_if;
    logic done_d;
    logic done_st;
    logic kill;

    assign idle    = (state == IDLE);
    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    assign if_gnt    = idle && if_req && (!d_req || starved);
    assign d_gnt     = idle && d_req && !if_gnt;
    assign mem_en    = if_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = mem_we ? d_wdata : '0;
    assign stall_if  = if_req && !if_gnt;
    assign busy      = (state == WAIT);

    // With MEM_LAT==1 the response is captured on the grant edge and no WAIT cycle exists.
    assign done_wait = (state == WAIT) && (lat_cnt == LAT_W'(1));
    assign done_now  = SINGLE && mem_en;
    assign done_if   = (done_wait && owner_if) || (done_now && if_gnt);
    assign done_d    = (done_wait && owner_d) || (done_now && d_gnt);
    assign done_st   = done_wait ? owner_st : d_we;
    assign kill      = flush || ((state == WAIT) && cancel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_if   <= 1'b0;
            owner_d    <= 1'b0;
            owner_st   <= 1'b0;
            cancel     <= 1'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && !starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (mem_en && !SINGLE) begin
                        state    <= WAIT;
                        lat_cnt  <= LAT_W'(MEM_LAT - 1);
                        owner_if <= if_gnt;
                        owner_d  <= d_gnt;
                        owner_st <= d_gnt && d_we;
                        cancel   <= if_gnt && flush;
                    end
                end
                WAIT: begin
                    if (owner_if && flush) begin
                        cancel <= 1'b1;
                    end
                    if (done_wait) begin
                        state    <= IDLE;
                        lat_cnt  <= '0;
                        owner_if <= 1'b0;
                        owner_d  <= 1'b0;
                        owner_st <= 1'b0;
                        cancel   <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // A cancelled fetch still consumes its slot but leaves if_rdata untouched.
            if (done_if && !kill) begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
            end
            if (done_d) begin
                d_valid <= 1'b1;
                d_rdata <= done_st ? '0 : mem_rdata;
            end
        end
    end
endmodule
